// File: rtl/float_op_dispatcher_if.sv
// Request, FU and response buses of the float add/sub issue stage.
// The slave modport is the dispatcher's view; master is the environment's.
interface float_op_dispatcher_if #(
    parameter int PRECISION = 32,
    parameter int TAG_W     = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [PRECISION-1:0] req_a;
    logic [PRECISION-1:0] req_b;
    logic                 req_op;
    logic [TAG_W-1:0]     req_tag;

    logic [PRECISION-1:0] fu_inA;
    logic [PRECISION-1:0] fu_inB;
    logic                 fu_op;
    logic                 fu_load;
    logic [PRECISION-1:0] fu_out;
    logic                 fu_valid;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [PRECISION-1:0] rsp_result;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_timeout;
    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag,
        input  fu_out, fu_valid,
        input  rsp_ready,
        output req_ready,
        output fu_inA, fu_inB, fu_op, fu_load,
        output rsp_valid, rsp_result, rsp_tag, rsp_timeout, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag,
        output fu_out, fu_valid,
        output rsp_ready,
        input  req_ready,
        input  fu_inA, fu_inB, fu_op, fu_load,
        input  rsp_valid, rsp_result, rsp_tag, rsp_timeout, busy
    );
endinterface

// File: rtl/float_op_dispatcher.sv
// Issue stage for the float add/sub FU: request FIFO, multi-cycle load pulse,
// result capture with tag, and a timeout that answers with canonical NaN.
module float_op_dispatcher #(
    parameter int PRECISION   = 32,
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int LOAD_CYCLES = 2,
    parameter int MAX_WAIT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    float_op_dispatcher_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int LC_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [LC_W-1:0]      LOAD_LAST = LC_W'(LOAD_CYCLES - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0]    WAIT_SAT  = WAIT_W'(MAX_WAIT);
    localparam logic [PRECISION-1:0] CANON_NAN = {1'b0, {(PRECISION-1){1'b1}}};

    typedef struct packed {
        logic [PRECISION-1:0] a;
        logic [PRECISION-1:0] b;
        logic                 op;
        logic [TAG_W-1:0]     tag;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full, empty, push, pop;

    state_t               state, state_next;
    logic [LC_W-1:0]      load_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 cap_fu, cap_to;

    logic [PRECISION-1:0] op_a, op_b, result;
    logic                 op_op, timeout;
    logic [TAG_W-1:0]     op_tag, rsp_tag_q;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = bus.req_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: bus.req_a, b: bus.req_b, op: bus.req_op, tag: bus.req_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Pop only from registered occupancy; RESP pops directly into LOAD to avoid an IDLE bubble.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cap_fu     = 1'b0;
        cap_to     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt == LOAD_LAST) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.fu_valid) begin
                    cap_fu     = 1'b1;
                    state_next = S_RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    cap_to     = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (pop)                   load_cnt <= '0;
            else if (state == S_LOAD)  load_cnt <= load_cnt + LC_W'(1);

            if (state == S_LOAD)                           wait_cnt <= '0;
            else if (state == S_WAIT && wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            op_op     <= 1'b0;
            op_tag    <= '0;
            result    <= '0;
            rsp_tag_q <= '0;
            timeout   <= 1'b0;
        end else begin
            if (pop) begin
                op_a   <= mem[rd_ptr].a;
                op_b   <= mem[rd_ptr].b;
                op_op  <= mem[rd_ptr].op;
                op_tag <= mem[rd_ptr].tag;
            end
            if (cap_fu || cap_to) begin
                result    <= cap_fu ? bus.fu_out : CANON_NAN;
                rsp_tag_q <= op_tag;
                timeout   <= cap_to;
            end
        end
    end

    assign bus.req_ready   = !full;
    assign bus.fu_inA      = op_a;
    assign bus.fu_inB      = op_b;
    assign bus.fu_op       = op_op;
    assign bus.fu_load     = (state == S_LOAD);
    assign bus.rsp_valid   = (state == S_RESP);
    assign bus.rsp_result  = result;
    assign bus.rsp_tag     = rsp_tag_q;
    assign bus.rsp_timeout = timeout;
    assign bus.busy        = (state != S_IDLE) || !empty;
endmodule

// File: tb/tb_float_op_dispatcher.sv
// Bench for float_op_dispatcher: stub FU answering from a hand-computed table,
// expected responses queued at push time and checked by a separate monitor.
module tb_float_op_dispatcher;
    localparam int P      = 32;
    localparam int TW     = 4;
    localparam int LC     = 2;
    localparam int MW     = 10;
    localparam int FU_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float_op_dispatcher_if #(.PRECISION(P), .TAG_W(TW)) bus ();

    float_op_dispatcher #(
        .PRECISION(P), .DEPTH(4), .TAG_W(TW), .LOAD_CYCLES(LC), .MAX_WAIT(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        to;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fu_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        case ({a, b, op})
            {32'h3FC00000, 32'h40100000, 1'b0}: return 32'h40700000;
            {32'h40A00000, 32'h40400000, 1'b1}: return 32'h40000000;
            {32'h3F800000, 32'h40000000, 1'b0}: return 32'h40400000;
            {32'h3F800000, 32'h3F800000, 1'b0}: return 32'h40000000;
            {32'h40000000, 32'h40000000, 1'b0}: return 32'h40800000;
            {32'h40400000, 32'h3F800000, 1'b1}: return 32'h40000000;
            {32'h40800000, 32'h3F800000, 1'b0}: return 32'h40A00000;
            {32'h3F800000, 32'h3F800000, 1'b1}: return 32'h00000000;
            {32'h40000000, 32'h40400000, 1'b0}: return 32'h40A00000;
            default:                            return 32'hDEADBEEF;
        endcase
    endfunction

    // Stub FU: latches operands during the load pulse, flags any change, answers FU_LAT cycles later.
    logic        fu_hang = 1'b0;
    logic        stale_pulse = 1'b0;
    logic [31:0] ld_a, ld_b;
    logic        ld_op;
    logic        seen = 1'b0, bad = 1'b0, armed = 1'b0;
    int          delay = 0;

    always @(posedge clk) begin
        bus.fu_valid <= stale_pulse;
        bus.fu_out   <= 32'h12345678;
        if (bus.fu_load) begin
            if (seen && (bus.fu_inA !== ld_a || bus.fu_inB !== ld_b || bus.fu_op !== ld_op)) bad <= 1'b1;
            ld_a  <= bus.fu_inA;
            ld_b  <= bus.fu_inB;
            ld_op <= bus.fu_op;
            seen  <= 1'b1;
            armed <= 1'b1;
            delay <= FU_LAT;
        end else if (armed) begin
            if (delay <= 1) begin
                armed <= 1'b0;
                seen  <= 1'b0;
                bad   <= 1'b0;
                if (!fu_hang) begin
                    bus.fu_valid <= 1'b1;
                    bus.fu_out   <= bad ? 32'hBADBAD00 : fu_model(ld_a, ld_b, ld_op);
                end
            end else begin
                delay <= delay - 1;
            end
        end
    end

    // Monitor: response order/content, hold stability, load pulse width, back-to-back loads.
    logic        held = 1'b0, want_load = 1'b0, b2b_mode = 1'b0;
    logic [31:0] h_res;
    logic [3:0]  h_tag;
    logic        h_to;
    int          run = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
            held = 1'b0;
            want_load = 1'b0;
        end else begin
            if (want_load) begin
                check("b2b_load", bus.fu_load, 1);
                want_load = 1'b0;
            end
            if (bus.fu_load) run++;
            else if (run > 0) begin
                check("load_width", run, LC);
                run = 0;
            end
            if (bus.rsp_valid && held) begin
                check("hold_result", bus.rsp_result, h_res);
                check("hold_tag", bus.rsp_tag, h_tag);
                check("hold_timeout", bus.rsp_timeout, h_to);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got tag %0d result %0h, required no response", bus.rsp_tag, bus.rsp_result);
                end else begin
                    e = sb.pop_front();
                    check("rsp_result", bus.rsp_result, e.res);
                    check("rsp_tag", bus.rsp_tag, e.tag);
                    check("rsp_timeout", bus.rsp_timeout, e.to);
                    if (b2b_mode && sb.size() > 0) want_load = 1'b1;
                end
            end else if (bus.rsp_valid) begin
                held  = 1'b1;
                h_res = bus.rsp_result;
                h_tag = bus.rsp_tag;
                h_to  = bus.rsp_timeout;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [3:0] tag,
                        input logic [31:0] er, input logic eto, input logic track);
        bit done = 0;
        bit rdy;
        int n = 0;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        while (!done && n < 200) begin
            rdy = bus.req_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1;
                if (track) sb.push_back('{res: er, tag: tag, to: eto});
            end
            n++;
            #1;
        end
        bus.req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_accept tag %0d: req_ready stayed 0, required 1", tag);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        int cnt;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = 1'b0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_req_ready", bus.req_ready, 1);
        check("rst_fu_load", bus.fu_load, 0);
        check("rst_fu_inA", bus.fu_inA, 0);
        check("rst_fu_inB", bus.fu_inB, 0);
        check("rst_fu_op", bus.fu_op, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_rsp_tag", bus.rsp_tag, 0);
        check("rst_rsp_timeout", bus.rsp_timeout, 0);
        check("rst_busy", bus.busy, 0);

        // Single add and subtract
        push(32'h3FC00000, 32'h40100000, 1'b0, 4'd3, 32'h40700000, 1'b0, 1'b1);
        push(32'h40A00000, 32'h40400000, 1'b1, 4'd7, 32'h40000000, 1'b0, 1'b1);
        drain();

        // Timeout with a hung FU, then a normal request
        fu_hang = 1'b1;
        push(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h7FFFFFFF, 1'b1, 1'b1);
        cnt = 0;
        while (!bus.fu_load && cnt < 50) begin step(); cnt++; end
        cnt = 0;
        while (bus.fu_load && cnt < 50) begin step(); cnt++; end
        cnt = 0;
        while (!bus.rsp_valid && cnt < 100) begin step(); cnt++; end
        check("timeout_wait_cycles", cnt, MW);
        drain();
        fu_hang = 1'b0;
        push(32'h3FC00000, 32'h40100000, 1'b0, 4'd3, 32'h40700000, 1'b0, 1'b1);
        drain();

        // Back-pressure: one response parked in RESP, FIFO filled, response held 20 cycles
        bus.rsp_ready = 1'b0;
        b2b_mode = 1'b1;
        push(32'h3F800000, 32'h3F800000, 1'b0, 4'd9, 32'h40000000, 1'b0, 1'b1);
        cnt = 0;
        while (!bus.rsp_valid && cnt < 50) begin step(); cnt++; end
        push(32'h3F800000, 32'h40000000, 1'b0, 4'd0, 32'h40400000, 1'b0, 1'b1);
        push(32'h40000000, 32'h40000000, 1'b0, 4'd1, 32'h40800000, 1'b0, 1'b1);
        push(32'h40400000, 32'h3F800000, 1'b1, 4'd2, 32'h40000000, 1'b0, 1'b1);
        push(32'h40800000, 32'h3F800000, 1'b0, 4'd3, 32'h40A00000, 1'b0, 1'b1);
        check("full_req_ready", bus.req_ready, 0);
        check("full_busy", bus.busy, 1);
        for (int i = 0; i < 20; i++) begin
            check("hold_fu_load", bus.fu_load, 0);
            check("hold_rsp_valid", bus.rsp_valid, 1);
            step();
        end
        bus.rsp_ready = 1'b1;
        push(32'h3F800000, 32'h3F800000, 1'b1, 4'd4, 32'h00000000, 1'b0, 1'b1);
        drain();
        b2b_mode = 1'b0;

        // Reset mid-WAIT with two requests queued; none of them may answer
        fu_hang = 1'b1;
        push(32'h3F800000, 32'h40000000, 1'b0, 4'd1, 32'h0, 1'b0, 1'b0);
        push(32'h40000000, 32'h40000000, 1'b0, 4'd2, 32'h0, 1'b0, 1'b0);
        push(32'h40400000, 32'h3F800000, 1'b1, 4'd3, 32'h0, 1'b0, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_req_ready", bus.req_ready, 1);
        check("mid_rst_fu_load", bus.fu_load, 0);
        stale_pulse = 1'b1;
        step(); step(); step();
        stale_pulse = 1'b0;
        fu_hang = 1'b0;
        repeat (20) step();
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_rsp_valid", bus.rsp_valid, 0);

        push(32'h40000000, 32'h40400000, 1'b0, 4'd6, 32'h40A00000, 1'b0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
